// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and helpers for the SRAM read/write master and its response buffer.
//   DefDataWidth / DefAddrWidth : SRAM word and address widths
//   DefRspDepth                 : read-response buffer entries
package sram_ctrl_pkg;

  localparam int unsigned DefDataWidth = 2;
  localparam int unsigned DefAddrWidth = 4;
  localparam int unsigned DefRspDepth  = 3;

  // Pointer width for a buffer of `depth` entries; a 1-entry buffer still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response FIFO for sram_rw_master.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the buffer)
//   push_i       : write wdata_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   rdata_o      : head entry, stable until popped
//   full_o       : all Depth entries occupied
//   empty_o      : no entries
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned Width = DefDataWidth,
  parameter int unsigned Depth = DefRspDepth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    full_o   = (cnt_q == CntW'(Depth));
    empty_o  = (cnt_q == '0);
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    rdata_o  = mem_q[rd_ptr_q];
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sram_rw_master.sv
// Request/response master for a single-port synchronous SRAM macro (1-cycle read latency).
//   clk0, rst0                                  : clock shared with the SRAM, sync active-high reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel (write or read)
//   rsp_valid/rsp_ready/rsp_rdata                 : read responses, in request order
//   csb0/web0/addr0/din0                          : registered SRAM control (active-low csb0/web0)
//   dout0                                         : SRAM read data
// A read accepted at edge N is presented to the SRAM during N..N+1, and dout0 is captured into
// the response FIFO at edge N+2. Reads in flight are tracked by a 2-stage tag shift.
module sram_rw_master
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RSP_DEPTH  = DefRspDepth
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  tag_issue_q, tag_issue_d;
  logic                  tag_cap_q, tag_cap_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic accept, rd_accept, pop, fifo_empty, fifo_full_unused;

  always_comb begin
    // Outstanding reads never exceed the FIFO depth, so a capture always finds room.
    req_ready   = !rst0 && (cnt_q < CntW'(RSP_DEPTH));
    accept      = req_valid && req_ready;
    rd_accept   = accept && !req_we;
    rsp_valid   = !rst0 && !fifo_empty;
    pop         = rsp_valid && rsp_ready;

    csb0_d      = !accept;
    web0_d      = accept ? !req_we : 1'b1;
    addr0_d     = accept ? req_addr : addr0_q;
    din0_d      = accept ? req_wdata : din0_q;

    tag_issue_d = rd_accept;
    tag_cap_d   = tag_issue_q;

    cnt_d       = cnt_q;
    unique case ({rd_accept, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      tag_issue_q <= 1'b0;
      tag_cap_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      tag_issue_q <= tag_issue_d;
      tag_cap_q   <= tag_cap_d;
      cnt_q       <= cnt_d;
    end
  end

  assign csb0  = csb0_q;
  assign web0  = web0_q;
  assign addr0 = addr0_q;
  assign din0  = din0_q;

  // tag_cap_q marks the edge at which dout0 holds data for a read issued two edges earlier.
  sram_rsp_fifo #(
    .Width (DATA_WIDTH),
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk0),
    .rst_i   (rst0),
    .push_i  (tag_cap_q),
    .wdata_i (dout0),
    .pop_i   (pop),
    .rdata_o (rsp_rdata),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_sram_rw_master.sv
// Directed and randomized bench for sram_rw_master with a behavioural SRAM macro.
// Reference model: a word array plus a queue of expected read responses, each tagged with the
// cycle from which it may be presented.
module tb_sram_rw_master;

  logic       clk0 = 1'b0;
  logic       rst0;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [1:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [1:0] rsp_rdata;
  logic       csb0, web0;
  logic [3:0] addr0;
  logic [1:0] din0, dout0;

  sram_rw_master dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  always #5 clk0 = ~clk0;

  // Behavioural SRAM macro: captures control at the rising edge, read data valid after it.
  logic [1:0] sram_mem [16];
  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) sram_mem[addr0] <= din0;
      else       dout0 <= sram_mem[addr0];
    end
  end

  typedef struct {
    logic [1:0] data;
    int         avail;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [1:0] model_mem [16];
  logic [3:0] exp_addr;
  logic [1:0] exp_din;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         dut_pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus; called at a falling edge, returns at the next falling edge.
  task automatic cycle(input logic v, input logic we, input logic [3:0] a, input logic [1:0] d,
                       input logic rr, output logic acc_dut);
    logic exp_ready, exp_valid, acc, pop;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    exp_ready = (exp_q.size() < 3);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    if (exp_valid) chk("rsp_rdata", {30'b0, rsp_rdata}, {30'b0, exp_q[0].data});
    acc_dut = v && req_ready;
    if (rr && rsp_valid) dut_pops++;
    acc = v && exp_ready;
    pop = rr && exp_valid;
    @(posedge clk0);
    cyc++;
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      if (we) model_mem[a] = d;
      else    exp_q.push_back('{data: model_mem[a], avail: cyc + 2});
      exp_addr = a;
      exp_din  = d;
    end
    @(negedge clk0);
    chk("csb0", {31'b0, csb0}, {31'b0, !acc});
    chk("web0", {31'b0, web0}, {31'b0, acc ? !we : 1'b1});
    chk("addr0", {28'b0, addr0}, {28'b0, exp_addr});
    chk("din0", {30'b0, din0}, {30'b0, exp_din});
  endtask

  task automatic do_reset(input int n);
    rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready_pre", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid_pre", {31'b0, rsp_valid}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk0);
      cyc++;
      @(negedge clk0);
      chk("rst_csb0", {31'b0, csb0}, 32'd1);
      chk("rst_web0", {31'b0, web0}, 32'd1);
      chk("rst_addr0", {28'b0, addr0}, 32'd0);
      chk("rst_din0", {30'b0, din0}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    end
    exp_q.delete();
    exp_addr = '0;
    exp_din  = '0;
    rst0 = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(1'b0, 1'b0, 4'h0, 2'b0, 1'b1, acc);
    chk("drain_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic acc;
    int   n;
    do_reset(2);

    // Idle: chip deselected every cycle.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 4'h0, 2'b0, 1'b1, acc);

    // Initialise every word with random data.
    for (int a = 0; a < 16; a++) cycle(1'b1, 1'b1, 4'(a), 2'($urandom), 1'b1, acc);

    // Write 3 <- 2'b10 then read it back.
    cycle(1'b1, 1'b1, 4'h3, 2'b10, 1'b1, acc);
    cycle(1'b1, 1'b0, 4'h3, 2'b00, 1'b1, acc);
    drain();

    // Back-to-back reads of all addresses.
    dut_pops = 0;
    for (int a = 0; a < 16; a++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) cycle(1'b1, 1'b0, 4'(a), 2'b0, 1'b1, acc);
      chk("b2b_accepted", {31'b0, acc}, 32'd1);
    end
    drain();
    chk("b2b_responses", dut_pops, 32'd16);

    // Responses stalled: only the buffer depth's worth of reads may be accepted.
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 4'($urandom), 2'b0, 1'b0, acc);
      if (acc) n++;
    end
    chk("stall_accepts", n, 32'd3);
    #1;
    chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    dut_pops = 0;
    drain();
    chk("stall_responses", dut_pops, 32'd3);

    // Reset one cycle after a read accept: that read never responds.
    cycle(1'b1, 1'b0, 4'h5, 2'b0, 1'b1, acc);
    do_reset(1);
    dut_pops = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'h0, 2'b0, 1'b1, acc);
    chk("rst_flush_pops", dut_pops, 32'd0);

    // Read immediately after write to the same address.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      a = 4'($urandom);
      cycle(1'b1, 1'b1, a, 2'($urandom), 1'b1, acc);
      cycle(1'b1, 1'b0, a, 2'b0, 1'b1, acc);
    end
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 2'($urandom),
            $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
